// File: rtl/spi_master_ss.sv
// rtl/spi_master_ss.sv - word-oriented SPI master with fixed CPOL/CPHA/SCK rate
// Optional slave-select generation with setup/hold guards: define SPI_MASTER_SS_EN.
module spi_master_ss #(
  parameter int WID               = 24,
  parameter int WID_LEN           = 5,
  parameter int CYCLE_HALF_WAIT   = 1,
  parameter int TIMER_WID         = 3,
  parameter bit POLARITY          = 1'b0,
  parameter bit PHASE             = 1'b0,
  parameter int SS_WAIT           = 1,
  parameter int SS_WAIT_TIMER_WID = 2
) (
  input  logic           clk,
  input  logic           rst_L,
  input  logic           arm,
  output logic           finished,
  output logic           ready,
  input  logic [WID-1:0] to_slave,
  output logic [WID-1:0] from_slave,
  output logic           sck_wire,
  output logic           mosi_wire,
  input  logic           miso_wire
`ifdef SPI_MASTER_SS_EN
  ,
  output logic           ss_L
`endif
);

  if ((2 ** WID_LEN) <= WID || (2 ** TIMER_WID) <= CYCLE_HALF_WAIT ||
      (2 ** SS_WAIT_TIMER_WID) <= SS_WAIT) begin : g_bad_cfg
    $error("spi_master_ss: counter widths too small for configuration");
  end

  typedef enum logic [2:0] {
    IDLE,
`ifdef SPI_MASTER_SS_EN
    SS_SETUP,
    SS_HOLD,
`endif
    SHIFT,
    WAIT_DISARM
  } state_t;

`ifdef SPI_MASTER_SS_EN
  localparam state_t AFTER_IDLE  = SS_SETUP;
  localparam state_t AFTER_SHIFT = SS_HOLD;
`else
  localparam state_t AFTER_IDLE  = SHIFT;
  localparam state_t AFTER_SHIFT = WAIT_DISARM;
`endif

  localparam logic [TIMER_WID-1:0] HALF_LAST = TIMER_WID'(CYCLE_HALF_WAIT);
  localparam logic [TIMER_WID-1:0] HALF_ONE  = TIMER_WID'(1);
  localparam logic [WID_LEN:0]     TOG_LAST  = (WID_LEN+1)'(2 * WID);
  localparam logic [WID_LEN:0]     TOG_FINAL = (WID_LEN+1)'(2 * WID - 1);
  localparam logic [WID_LEN:0]     TOG_ONE   = (WID_LEN+1)'(1);

  state_t               state, state_n;
  logic [TIMER_WID-1:0] half_timer;
  logic [WID_LEN:0]     tog_cnt;
  logic [WID-1:0]       tx_sr, rx_sr;
  logic                 accept, sck_edge, shift_done, leading, enter_wait;
  logic                 ss_done;

  assign accept     = (state == IDLE) && arm;
  assign sck_edge   = (state == SHIFT) && (tog_cnt != TOG_LAST) && (half_timer == HALF_LAST);
  assign shift_done = (state == SHIFT) && (tog_cnt == TOG_LAST);
  assign leading    = (sck_wire == POLARITY);
  assign enter_wait = (state != WAIT_DISARM) && (state_n == WAIT_DISARM);
  assign ready      = (state == IDLE);
  assign finished   = (state == WAIT_DISARM);

`ifdef SPI_MASTER_SS_EN
  localparam logic [SS_WAIT_TIMER_WID-1:0] SS_LAST = SS_WAIT_TIMER_WID'(SS_WAIT);
  localparam logic [SS_WAIT_TIMER_WID-1:0] SS_ONE  = SS_WAIT_TIMER_WID'(1);
  logic [SS_WAIT_TIMER_WID-1:0] ss_timer;

  assign ss_done = (ss_timer == SS_LAST);

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      ss_L     <= 1'b1;
      ss_timer <= '0;
    end else begin
      if (accept) ss_L <= 1'b0;
      if (state == SS_SETUP || state == SS_HOLD) begin
        if (ss_done) begin
          ss_timer <= '0;
          if (state == SS_HOLD) ss_L <= 1'b1;
        end else begin
          ss_timer <= ss_timer + SS_ONE;
        end
      end
    end
  end
`else
  assign ss_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_L) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (arm) state_n = AFTER_IDLE;
`ifdef SPI_MASTER_SS_EN
      SS_SETUP:    if (ss_done) state_n = SHIFT;
      SS_HOLD:     if (ss_done) state_n = WAIT_DISARM;
`endif
      SHIFT:       if (shift_done) state_n = AFTER_SHIFT;
      WAIT_DISARM: if (!arm) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  // Sampling edge is leading for PHASE=0 and trailing for PHASE=1; driving is the other one.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      sck_wire   <= POLARITY;
      mosi_wire  <= 1'b0;
      from_slave <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      half_timer <= '0;
      tog_cnt    <= '0;
    end else begin
      if (accept) begin
        tx_sr      <= PHASE ? to_slave : {to_slave[WID-2:0], 1'b0};
        if (!PHASE) mosi_wire <= to_slave[WID-1];
        rx_sr      <= '0;
        half_timer <= '0;
        tog_cnt    <= '0;
      end
      if (sck_edge) begin
        half_timer <= '0;
        sck_wire   <= ~sck_wire;
        tog_cnt    <= tog_cnt + TOG_ONE;
        if (leading != PHASE) begin
          rx_sr <= {rx_sr[WID-2:0], miso_wire};
        end else if (PHASE || tog_cnt != TOG_FINAL) begin
          mosi_wire <= tx_sr[WID-1];
          tx_sr     <= {tx_sr[WID-2:0], 1'b0};
        end
      end else if (state == SHIFT && !shift_done) begin
        half_timer <= half_timer + HALF_ONE;
      end
      if (enter_wait) begin
        from_slave <= rx_sr;
        mosi_wire  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ss.sv
// tb/tb_spi_master_ss.sv - self-checking bench for spi_master_ss (three configurations side by side)
// Honours SPI_MASTER_SS_EN when the design is built with it.
module tb_spi_master_ss;
  localparam int WID = 24;
`ifdef SPI_MASTER_SS_EN
  localparam int PRE = 2;
  localparam int LAT0 = 101;
  localparam int LAT2 = 53;
`else
  localparam int PRE = 0;
  localparam int LAT0 = 97;
  localparam int LAT2 = 49;
`endif

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic arm = 1'b0;
  logic [23:0] ts [3];
  logic [23:0] fs [3];
  logic [2:0] sck, mosi, fin, rdy, ss;
  logic miso0, miso1, miso2;
  logic [23:0] resp1 = 24'h123456;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign miso0 = mosi[0];
  assign miso2 = mosi[2];

  spi_master_ss #(.CYCLE_HALF_WAIT(1), .POLARITY(1'b0), .PHASE(1'b0)) dut0 (
    .clk(clk), .rst_L(rst_L), .arm(arm), .finished(fin[0]), .ready(rdy[0]),
    .to_slave(ts[0]), .from_slave(fs[0]), .sck_wire(sck[0]), .mosi_wire(mosi[0]),
    .miso_wire(miso0)
`ifdef SPI_MASTER_SS_EN
    , .ss_L(ss[0])
`endif
  );
  spi_master_ss #(.CYCLE_HALF_WAIT(1), .POLARITY(1'b1), .PHASE(1'b1)) dut1 (
    .clk(clk), .rst_L(rst_L), .arm(arm), .finished(fin[1]), .ready(rdy[1]),
    .to_slave(ts[1]), .from_slave(fs[1]), .sck_wire(sck[1]), .mosi_wire(mosi[1]),
    .miso_wire(miso1)
`ifdef SPI_MASTER_SS_EN
    , .ss_L(ss[1])
`endif
  );
  spi_master_ss #(.CYCLE_HALF_WAIT(0), .POLARITY(1'b0), .PHASE(1'b0)) dut2 (
    .clk(clk), .rst_L(rst_L), .arm(arm), .finished(fin[2]), .ready(rdy[2]),
    .to_slave(ts[2]), .from_slave(fs[2]), .sck_wire(sck[2]), .mosi_wire(mosi[2]),
    .miso_wire(miso2)
`ifdef SPI_MASTER_SS_EN
    , .ss_L(ss[2])
`endif
  );
`ifndef SPI_MASTER_SS_EN
  assign ss = 3'b111;
`endif

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
    end
  endtask

  function automatic int h1_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction
  function automatic logic pol_of(input int d);
    return d == 1;
  endfunction
  function automatic logic pha_of(input int d);
    return d == 1;
  endfunction
  function automatic int lat_of(input int d);
    return 2 * PRE + 2 * WID * h1_of(d) + 1;
  endfunction
  // Toggles completed k cycles after acceptance: one every half period once the guard has elapsed.
  function automatic int exp_t(input int d, input int k);
    int t;
    if (k <= PRE) return 0;
    t = (k - PRE) / h1_of(d);
    if (t > 2 * WID) t = 2 * WID;
    return t;
  endfunction
  function automatic logic exp_mosi(input int d, input int k, input logic [23:0] w);
    int t, b;
    t = exp_t(d, k);
    if (!pha_of(d)) begin
      b = t / 2;
      if (b > WID - 1) b = WID - 1;
      return w[WID-1-b];
    end
    b = (t + 1) / 2;
    if (b == 0) return 1'b0;
    return w[WID-b];
  endfunction

  // Model: 0 idle, 1 busy (mk cycles since acceptance), 2 waiting for disarm.
  int mst [3] = '{0, 0, 0};
  int mk [3] = '{0, 0, 0};
  logic [23:0] mword [3];
  logic [23:0] mfrom [3] = '{24'h0, 24'h0, 24'h0};
  int lat [3] = '{0, 0, 0};
  int cnt [3] = '{0, 0, 0};
  int tog [3] = '{0, 0, 0};
  int rise [3] = '{0, 0, 0};
  int fhi [3] = '{0, 0, 0};
  logic [2:0] rdy_p = 3'b111, fin_p = 3'b000, sck_p = 3'b010;

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_L) begin
        mst[d] = 0;
        mfrom[d] = '0;
      end else begin
        case (mst[d])
          0: if (arm) begin mst[d] = 1; mk[d] = 0; mword[d] = ts[d]; end
          1: begin
            mk[d]++;
            if (mk[d] == lat_of(d)) begin
              mst[d] = 2;
              mfrom[d] = (d == 1) ? resp1 : mword[d];
            end
          end
          default: if (!arm) mst[d] = 0;
        endcase
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      logic e_sck, e_mosi;
      int t;
      e_sck = pol_of(d);
      e_mosi = 1'b0;
      if (mst[d] == 1) begin
        t = exp_t(d, mk[d]);
        e_sck = pol_of(d) ^ t[0];
        e_mosi = exp_mosi(d, mk[d], mword[d]);
      end
      chk("sck", d, {31'd0, sck[d]}, {31'd0, e_sck});
      chk("mosi", d, {31'd0, mosi[d]}, {31'd0, e_mosi});
      chk("ready", d, {31'd0, rdy[d]}, {31'd0, mst[d] == 0});
      chk("finished", d, {31'd0, fin[d]}, {31'd0, mst[d] == 2});
      chk("from_slave", d, {8'd0, fs[d]}, {8'd0, mfrom[d]});
`ifdef SPI_MASTER_SS_EN
      chk("ss_L", d, {31'd0, ss[d]}, {31'd0, mst[d] != 1});
`endif
      if (rdy_p[d] && !rdy[d]) begin
        cnt[d] = 0; tog[d] = 0; rise[d] = 0; fhi[d] = 0;
      end else begin
        cnt[d]++;
      end
      if (sck[d] != sck_p[d]) begin
        tog[d]++;
        if (sck[d]) rise[d]++;
      end
      if (fin[d] && !fin_p[d]) lat[d] = cnt[d];
      if (fin[d]) fhi[d]++;
    end
    rdy_p = rdy;
    fin_p = fin;
    sck_p = sck;
  end

  // Slave for dut1 (CPOL=1): presents the next response bit on each falling (leading) SCK edge.
  int scnt = 0;
  logic sck1_p = 1'b1;
  always @(negedge clk) begin
    if (rdy[1]) begin
      scnt = 0;
      miso1 = 1'b0;
    end else if (sck[1] != sck1_p && sck[1] == 1'b0) begin
      if (scnt < WID) miso1 = resp1[WID-1-scnt];
      scnt++;
    end
    sck1_p = sck[1];
  end

  task automatic wait_fin(input int lim);
    int n = 0;
    while (fin != 3'b111 && n < lim) begin @(negedge clk); n++; end
    checks++;
    if (fin != 3'b111) begin
      failures++;
      $display("FAIL wait_fin timeout finished=%b required=111", fin);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (rdy != 3'b111 && n < lim) begin @(negedge clk); n++; end
    checks++;
    if (rdy != 3'b111) begin
      failures++;
      $display("FAIL wait_idle timeout ready=%b required=111", rdy);
    end
  endtask

  initial begin
    ts[0] = '0; ts[1] = '0; ts[2] = '0;
    miso1 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", d, {31'd0, rdy[d]}, 32'd1);
      chk("rst_finished", d, {31'd0, fin[d]}, 32'd0);
      chk("rst_from", d, {8'd0, fs[d]}, 32'd0);
    end
    chk("rst_sck_idle", 1, {31'd0, sck[1]}, 32'd1);
    @(negedge clk) rst_L = 1'b1;

    // Transfer A: arm held, then held 300 more cycles after completion
    @(negedge clk);
    ts[0] = 24'hA5C30F; ts[1] = 24'h0F0F0F; ts[2] = 24'hFFFFFF; arm = 1'b1;
    wait_fin(400);
    repeat (300) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("held_finished", d, {31'd0, fin[d]}, 32'd1);
      chk("held_ready", d, {31'd0, rdy[d]}, 32'd0);
      chk("toggles", d, tog[d], 32'd48);
    end
    chk("rising_edges", 0, rise[0], 32'd24);
    chk("latency", 0, lat[0], LAT0);
    chk("latency", 1, lat[1], LAT0);
    chk("latency", 2, lat[2], LAT2);
    chk("word", 0, {8'd0, fs[0]}, 32'h00A5C30F);
    chk("word", 1, {8'd0, fs[1]}, 32'h00123456);
    chk("word", 2, {8'd0, fs[2]}, 32'h00FFFFFF);
    @(negedge clk) arm = 1'b0;
    @(posedge clk); #2;
    for (int d = 0; d < 3; d++) begin
      chk("disarm_finished", d, {31'd0, fin[d]}, 32'd0);
      chk("disarm_ready", d, {31'd0, rdy[d]}, 32'd1);
    end

    // Transfer B: arm dropped mid-shift
    @(negedge clk);
    ts[0] = 24'h3C5A96; ts[1] = 24'hFFFFFF; ts[2] = 24'h000000; arm = 1'b1;
    repeat (25) @(negedge clk);
    arm = 1'b0;
    wait_idle(400);
    for (int d = 0; d < 3; d++) begin
      chk("pulse_width", d, fhi[d], 32'd1);
      chk("toggles_b", d, tog[d], 32'd48);
    end
    chk("word_b", 0, {8'd0, fs[0]}, 32'h003C5A96);
    chk("word_b", 1, {8'd0, fs[1]}, 32'h00123456);
    chk("word_b", 2, {8'd0, fs[2]}, 32'h00000000);

    // Transfer C: reset mid-shift, then a clean transfer
    @(negedge clk);
    ts[0] = 24'h5A5A5A; ts[1] = 24'h000000; ts[2] = 24'h9E3701; arm = 1'b1;
    repeat (30) @(negedge clk);
    rst_L = 1'b0; arm = 1'b0;
    @(posedge clk); #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_mid_sck", d, {31'd0, sck[d]}, {31'd0, pol_of(d)});
      chk("rst_mid_mosi", d, {31'd0, mosi[d]}, 32'd0);
      chk("rst_mid_fin", d, {31'd0, fin[d]}, 32'd0);
      chk("rst_mid_ready", d, {31'd0, rdy[d]}, 32'd1);
      chk("rst_mid_from", d, {8'd0, fs[d]}, 32'd0);
      chk("rst_mid_ss", d, {31'd0, ss[d]}, 32'd1);
    end
    @(negedge clk) rst_L = 1'b1;
    @(negedge clk);
    ts[0] = 24'hC3A50F; ts[1] = 24'hAAAAAA; ts[2] = 24'h9E3701; arm = 1'b1;
    wait_fin(400);
    chk("word_c", 0, {8'd0, fs[0]}, 32'h00C3A50F);
    chk("word_c", 1, {8'd0, fs[1]}, 32'h00123456);
    chk("word_c", 2, {8'd0, fs[2]}, 32'h009E3701);
    chk("toggles_c", 0, tog[0], 32'd48);
    @(negedge clk) arm = 1'b0;
    wait_idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
